// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: opcode type and constants,
// IR field positions and the sequencer state enumeration.
package cpu_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_ADD = 5'b00011;
    localparam opcode_t OP_SUB = 5'b00100;
    localparam opcode_t OP_AND = 5'b00101;
    localparam opcode_t OP_OR  = 5'b00110;
    localparam opcode_t OP_MUL = 5'b01110;
    localparam opcode_t OP_DIV = 5'b01111;

    localparam int unsigned IR_OP_MSB = 31;
    localparam int unsigned IR_OP_LSB = 27;
    localparam int unsigned IR_RA_MSB = 26;
    localparam int unsigned IR_RA_LSB = 23;
    localparam int unsigned IR_RB_MSB = 22;
    localparam int unsigned IR_RB_LSB = 19;
    localparam int unsigned IR_RC_MSB = 18;
    localparam int unsigned IR_RC_LSB = 15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_HALT
    } state_t;

endpackage

// File: rtl/control_seq_if.sv
// Control sequencer bundle: run/IR/memory-ready inputs and all datapath
// control strobes. master = sequencer side, slave = datapath side.
interface control_seq_if;
    import cpu_pkg::*;

    logic        run;
    logic [31:0] ir;
    logic        mem_rdy;

    logic    PCout, Zlowout, Zhighout, MDRout;
    logic    MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic    IncPC, Read;
    logic    Gra, Grb, Grc, Rin, Rout;
    opcode_t Operator;
    logic    done;
    logic    illegal;

    modport master (
        input  run, ir, mem_rdy,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        output Operator, done, illegal
    );

    modport slave (
        output run, ir, mem_rdy,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout,
        input  Operator, done, illegal
    );

endinterface

// File: rtl/opcode_decode.sv
// Combinational opcode classifier. MUL/DIV are legal only when
// CONTROL_SEQ_MULDIV_EN is defined.
module opcode_decode
    import cpu_pkg::*;
(
    input  opcode_t op,
    output logic    legal,
    output logic    is_muldiv
);

    always_comb begin
        legal     = '0;
        is_muldiv = '0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: legal = '1;
`ifdef CONTROL_SEQ_MULDIV_EN
            OP_MUL, OP_DIV: begin
                legal     = '1;
                is_muldiv = '1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/control_seq.sv
// Moore control sequencer: fetch T0-T2, execute T3-T5 (T6 for MUL/DIV when
// CONTROL_SEQ_MULDIV_EN is defined), sticky HALT on an illegal opcode.
module control_seq
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          clear,
    control_seq_if.master bus
);

    state_t  state, state_nx;
    opcode_t op_q;
    logic    illegal_q;
    logic    t1_stall;
    logic    legal, is_muldiv;

    opcode_decode u_dec (
        .op        (op_q),
        .legal     (legal),
        .is_muldiv (is_muldiv)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state     <= S_IDLE;
            op_q      <= '0;
            illegal_q <= '0;
            t1_stall  <= '0;
        end else begin
            state    <= state_nx;
            // T1 is always entered from T0, so this is low only in its first cycle
            t1_stall <= (state == S_T1);
            if (state == S_T2) op_q <= bus.ir[IR_OP_MSB:IR_OP_LSB];
            if (state == S_T3 && !legal) illegal_q <= '1;
        end
    end

    assign bus.illegal = illegal_q;

    always_comb begin
        state_nx     = state;
        bus.PCout    = '0;
        bus.Zlowout  = '0;
        bus.Zhighout = '0;
        bus.MDRout   = '0;
        bus.MARin    = '0;
        bus.PCin     = '0;
        bus.MDRin    = '0;
        bus.IRin     = '0;
        bus.Yin      = '0;
        bus.Zin      = '0;
        bus.HIin     = '0;
        bus.LOin     = '0;
        bus.IncPC    = '0;
        bus.Read     = '0;
        bus.Gra      = '0;
        bus.Grb      = '0;
        bus.Grc      = '0;
        bus.Rin      = '0;
        bus.Rout     = '0;
        bus.Operator = '0;
        bus.done     = '0;

        case (state)
            S_IDLE: if (bus.run) state_nx = S_T0;
            S_T0: begin
                bus.PCout = '1;
                bus.MARin = '1;
                bus.IncPC = '1;
                bus.Zin   = '1;
                state_nx  = S_T1;
            end
            S_T1: begin
                bus.Zlowout = '1;
                bus.Read    = '1;
                bus.MDRin   = '1;
                bus.PCin    = !t1_stall;
                if (bus.mem_rdy) state_nx = S_T2;
            end
            S_T2: begin
                bus.MDRout = '1;
                bus.IRin   = '1;
                state_nx   = S_T3;
            end
            S_T3: begin
                if (legal) begin
                    bus.Grb  = '1;
                    bus.Rout = '1;
                    bus.Yin  = '1;
                    state_nx = S_T4;
                end else begin
                    state_nx = S_HALT;
                end
            end
            S_T4: begin
                bus.Grc      = '1;
                bus.Rout     = '1;
                bus.Zin      = '1;
                bus.Operator = op_q;
                state_nx     = S_T5;
            end
            S_T5: begin
                bus.Zlowout = '1;
                if (is_muldiv) begin
`ifdef CONTROL_SEQ_MULDIV_EN
                    bus.LOin = '1;
                    state_nx = S_T6;
`else
                    state_nx = S_IDLE;
`endif
                end else begin
                    bus.Gra  = '1;
                    bus.Rin  = '1;
                    bus.done = '1;
                    state_nx = bus.run ? S_T0 : S_IDLE;
                end
            end
`ifdef CONTROL_SEQ_MULDIV_EN
            S_T6: begin
                bus.Zhighout = '1;
                bus.HIin     = '1;
                bus.done     = '1;
                state_nx     = bus.run ? S_T0 : S_IDLE;
            end
`endif
            S_HALT: ;
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_seq.sv
// Directed bench for control_seq: instruction-script model compared every
// cycle, plus literal spot checks. Honours CONTROL_SEQ_MULDIV_EN.
module tb_control_seq;

    logic clk;
    logic clear;
    control_seq_if bus();

    control_seq dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [25:0] M_PCOUT = 26'd1 << 25;
    localparam logic [25:0] M_ZLOW  = 26'd1 << 24;
    localparam logic [25:0] M_ZHIGH = 26'd1 << 23;
    localparam logic [25:0] M_MDROUT= 26'd1 << 22;
    localparam logic [25:0] M_MARIN = 26'd1 << 21;
    localparam logic [25:0] M_PCIN  = 26'd1 << 20;
    localparam logic [25:0] M_MDRIN = 26'd1 << 19;
    localparam logic [25:0] M_IRIN  = 26'd1 << 18;
    localparam logic [25:0] M_YIN   = 26'd1 << 17;
    localparam logic [25:0] M_ZIN   = 26'd1 << 16;
    localparam logic [25:0] M_HIIN  = 26'd1 << 15;
    localparam logic [25:0] M_LOIN  = 26'd1 << 14;
    localparam logic [25:0] M_INCPC = 26'd1 << 13;
    localparam logic [25:0] M_READ  = 26'd1 << 12;
    localparam logic [25:0] M_GRA   = 26'd1 << 11;
    localparam logic [25:0] M_GRB   = 26'd1 << 10;
    localparam logic [25:0] M_GRC   = 26'd1 << 9;
    localparam logic [25:0] M_RIN   = 26'd1 << 8;
    localparam logic [25:0] M_ROUT  = 26'd1 << 7;
    localparam logic [25:0] M_DONE  = 26'd1 << 1;
    localparam logic [25:0] M_ILL   = 26'd1;

    localparam logic [25:0] W_T0  = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
    localparam logic [25:0] W_T1  = M_ZLOW | M_PCIN | M_READ | M_MDRIN;
    localparam logic [25:0] W_T2  = M_MDROUT | M_IRIN;
    localparam logic [25:0] W_T3  = M_GRB | M_ROUT | M_YIN;
    localparam logic [25:0] W_T4  = M_GRC | M_ROUT | M_ZIN;
    localparam logic [25:0] W_T5A = M_ZLOW | M_GRA | M_RIN | M_DONE;
    localparam logic [25:0] W_T5M = M_ZLOW | M_LOIN;
    localparam logic [25:0] W_T6  = M_ZHIGH | M_HIIN | M_DONE;

    logic [25:0] dut_w;
    assign dut_w = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout,
                    bus.MARin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.Zin,
                    bus.HIin, bus.LOin, bus.IncPC, bus.Read,
                    bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
                    bus.Operator, bus.done, bus.illegal};

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Instruction-level model: each instruction is a script of output words
    logic [25:0] script [8];
    int          slen = 0;
    int          idx = 0;
    bit          active = 0, halted = 0, stall = 0;
    logic [25:0] exp_w = '0;

    function automatic bit op_legal(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return 1'b1;
`ifdef CONTROL_SEQ_MULDIV_EN
            5'b01110, 5'b01111: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic build(input logic [31:0] instr);
        logic [4:0] op;
        op = instr[31:27];
        script[0] = W_T0;
        script[1] = W_T1;
        script[2] = W_T2;
        if (!op_legal(op)) begin
            script[3] = '0;
            slen = 4;
        end else begin
            script[3] = W_T3;
            script[4] = W_T4 | {19'b0, op, 2'b0};
            if (op == 5'b01110 || op == 5'b01111) begin
                script[5] = W_T5M;
                script[6] = W_T6;
                slen = 7;
            end else begin
                script[5] = W_T5A;
                slen = 6;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or posedge clear);
        if (clear) begin
            active = 0; halted = 0; stall = 0; idx = 0;
        end else if (halted) begin
        end else if (!active) begin
            if (bus.run) begin
                build(bus.ir);
                active = 1; idx = 0; stall = 0;
            end
        end else if (idx == 1 && !bus.mem_rdy) begin
            stall = 1;
        end else begin
            stall = 0;
            if (idx == slen - 1) begin
                if (script[idx] == '0) halted = 1;
                else if (bus.run) begin
                    build(bus.ir);
                    idx = 0;
                end else active = 0;
            end else idx++;
        end
        exp_w = halted ? M_ILL : !active ? '0 : stall ? (script[idx] & ~M_PCIN) : script[idx];
    end

    initial forever begin
        @(negedge clk);
        vectors++;
        if (dut_w !== exp_w) begin
            miscompares++;
            $display("FAIL model_cmp: got %07h expected %07h at %0t", dut_w, exp_w, $time);
        end
        vectors++;
        if ($countones({bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.Rout}) > 1) begin
            miscompares++;
            $display("FAIL bus_onehot: got %07h expected at most one driver at %0t", dut_w, $time);
        end
    end

    task automatic pulse_clear(input string nm);
        #1 clear = 1'b1;
        #1 chk(nm, {6'b0, dut_w}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
    endtask

    int done_cnt, done_at, hilo_cnt, pcin_cnt, read_cnt, halt_cnt;

    initial begin
        clear = 1'b1;
        bus.run = 1'b0;
        bus.mem_rdy = 1'b1;
        bus.ir = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {6'b0, dut_w}, 32'd0);
        clear = 1'b0;
        @(negedge clk);
        chk("idle_without_run", {6'b0, dut_w}, 32'd0);

`ifdef CONTROL_SEQ_MULDIV_EN
        // mul R5,R2,R4
        bus.ir = 32'h72920000; bus.run = 1'b1;
        done_cnt = 0; done_at = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) bus.run = 1'b0;
            if (c == 5) chk("mul_t4_operator", {27'b0, bus.Operator}, 32'h0e);
            if (c == 6) chk("mul_t5_loin", {31'b0, bus.LOin}, 32'd1);
            if (c == 7) chk("mul_t6_hiin", {31'b0, bus.HIin}, 32'd1);
            if (bus.done) begin done_cnt++; done_at = c; end
        end
        chk("mul_done_cycle", done_at, 7);
        chk("mul_done_count", done_cnt, 1);
`else
        // mul opcode is not supported in this build
        bus.ir = 32'h72920000; bus.run = 1'b1;
        hilo_cnt = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) bus.run = 1'b0;
            if (c == 5) chk("mul_illegal_set", {31'b0, bus.illegal}, 32'd1);
            hilo_cnt += int'(bus.HIin) + int'(bus.LOin);
        end
        chk("mul_no_hilo", hilo_cnt, 0);
        chk("mul_halt_word", {6'b0, dut_w}, 32'd1);
        pulse_clear("mul_clear_async");
        @(negedge clk);
`endif

        // add R3,R2,R4 back-to-back with a second one, then stop
        bus.ir = 32'h19920000; bus.run = 1'b1;
        done_cnt = 0; done_at = 0; hilo_cnt = 0;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 6) chk("add_t5_word", {6'b0, dut_w & (M_GRA | M_RIN | M_DONE | M_LOIN | M_HIIN)},
                            {6'b0, M_GRA | M_RIN | M_DONE});
            if (c == 7) begin
                chk("add_next_t0", {31'b0, bus.PCout}, 32'd1);
                bus.run = 1'b0;
            end
            if (bus.done) begin done_cnt++; done_at = c; end
            hilo_cnt += int'(bus.HIin) + int'(bus.LOin);
        end
        chk("add_done_count", done_cnt, 2);
        chk("add_last_done", done_at, 12);
        chk("add_no_hilo", hilo_cnt, 0);

        // sub with a 3-cycle memory stall
        bus.ir = 32'h21920000; bus.run = 1'b1;
        done_at = 0; pcin_cnt = 0; read_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin bus.run = 1'b0; bus.mem_rdy = 1'b0; end
            if (c == 5) bus.mem_rdy = 1'b1;
            if (c == 2) chk("stall_first_pcin", {31'b0, bus.PCin}, 32'd1);
            if (c >= 2 && c <= 5) begin
                pcin_cnt += int'(bus.PCin);
                read_cnt += int'(bus.Read);
            end
            if (c == 8) chk("stall_t4_operator", {27'b0, bus.Operator}, 32'h04);
            if (bus.done) done_at = c;
        end
        chk("stall_pcin_count", pcin_cnt, 1);
        chk("stall_read_count", read_cnt, 4);
        chk("stall_done_cycle", done_at, 9);

        // opcode 11111 halts and stays halted
        bus.ir = 32'hF8000000; bus.run = 1'b1;
        halt_cnt = 0;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (c == 1) bus.run = 1'b0;
            if (c == 4) chk("ill_t3_quiet", {6'b0, dut_w}, 32'd0);
            if (c >= 5 && dut_w == 26'd1) halt_cnt++;
        end
        chk("ill_halt_cycles", halt_cnt, 11);
        pulse_clear("ill_clear_async");
        chk("ill_cleared", {31'b0, bus.illegal}, 32'd0);
        @(negedge clk);
        chk("ill_idle_after_clear", {6'b0, dut_w}, 32'd0);

        // asynchronous clear during T4, then restart with run held high
        bus.ir = 32'h19920000; bus.run = 1'b1;
        for (int c = 1; c <= 5; c++) @(negedge clk);
        chk("clr_t4_operator", {27'b0, bus.Operator}, 32'h03);
        pulse_clear("clr_mid_t4");
        @(negedge clk);
        chk("clr_restart_t0", {31'b0, bus.PCout}, 32'd1);
        bus.run = 1'b0;
        repeat (8) @(negedge clk);

        // run dropped in T3 does not abort the instruction
        bus.ir = 32'h19920000; bus.run = 1'b1;
        done_at = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 4) bus.run = 1'b0;
            if (bus.done) done_at = c;
            if (c == 7) chk("rundrop_idle", {6'b0, dut_w}, 32'd0);
        end
        chk("rundrop_done_cycle", done_at, 6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
